mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
Multi-cycle sequencer for the MULT/MULTU/DIV/DIVU datapath and owner of the architectural HI/LO register pair. Sits beside the ALU in the execute stage and accepts one operation at a time through a start/busy handshake. Runs a 32-iteration shift-add multiply or restoring divide on operand magnitudes, then writes HI/LO. Also services MTHI/MTLO writes and drives HI/LO for MFHI/MFLO.

Parameters:
WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH
CNT_W, $clog2(WIDTH), iteration counter width

Ports:
clk  in  1  clock, rising-edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request new operation; sampled only when busy=0
op  in  2  mult_op_enum: ALU_MULT=0, ALU_DIV=1; other codes treated as ALU_MULT
sign  in  1  1=signed (MULT/DIV), 0=unsigned (MULTU/DIVU)
src_a  in  WIDTH  multiplicand / dividend (rs)
src_b  in  WIDTH  multiplier / divisor (rt)
flush  in  1  abort in-flight operation
mthi  in  1  write wdata to HI
mtlo  in  1  write wdata to LO
wdata  in  WIDTH  MTHI/MTLO data
busy  out  1  operation in flight; execute stage stalls on busy
done  out  1  one-cycle pulse; HI/LO hold new result in this cycle
div_zero  out  1  sticky flag of last completed op: 1 if it was a divide by zero
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (async, rst_n=0): state=IDLE, hi=0, lo=0, busy=0, done=0, div_zero=0, counter=0. Reset mid-operation discards the operation; no done.
- busy is 1 whenever state != IDLE (driven from state register).
- States: IDLE, PREP, CALC, FIX.
- IDLE: start=1 at edge N latches op, sign, src_a, src_b; -> PREP.
- PREP (edge N+1): compute magnitudes (two's-complement negate when sign=1 and MSB=1), record result signs. If op=DIV and src_b=0 -> FIX with dz marker; else -> CALC, counter=0.
- CALC (edges N+2..N+33): one iteration per edge, MSB-first for divide, LSB-first shift-add for multiply; after the 32nd iteration (counter=WIDTH-1) -> FIX.
- FIX (edge N+34; N+2 for divide by zero): apply sign correction, write HI/LO, done=1 for exactly one cycle, div_zero updated, -> IDLE. Back-to-back start is accepted on the first IDLE cycle after done.
- Multiply: 2*WIDTH product; HI=upper, LO=lower. Signed: negate 64-bit product if sign(a)^sign(b).
- Divide: LO=quotient, HI=remainder. Signed: quotient negated if sign(a)^sign(b); remainder takes sign of dividend (truncate toward zero).
- Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000, no error flag.
- Divide by zero (either signedness): HI=src_a, LO=0xFFFFFFFF, div_zero=1; latency 2 edges.
- start while busy=1: ignored (no queueing); the issuing stage must hold.
- flush=1: any state -> IDLE on next edge; HI/LO, div_zero unchanged; no done. flush in IDLE with start=1: start dropped.
- mthi/mtlo: applied on the edge only when busy=0; ignored while busy=1. mthi+mtlo together write both. Same edge as accepted start: write applied, later overwritten by the result in FIX.
- hi/lo are register outputs; MFHI/MFLO read them directly and see completed values from the done cycle onward.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF, start at edge N -> busy high N+1..N+34, done pulse after edge N+34, HI=0xFFFFFFFE, LO=0x00000001.
- MULT signed 0xFFFFFFFD(-3)*0x00000007 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; MULT 0x80000000*0x80000000 -> HI=0x40000000, LO=0.
- DIV signed -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 -> LO=3, HI=1; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 0x00001234/0 -> done after edge N+2, HI=0x00001234, LO=0xFFFFFFFF, div_zero=1; following MULTU 2*3 -> div_zero=0, LO=6, HI=0.
- MTHI 0xAAAA5555 in IDLE -> hi updates next edge; start MULTU then MTLO 0x1 while busy -> lo unchanged until result; second start while busy ignored (single done).
- flush at edge N+10 of a DIV -> busy=0 after N+11, no done, HI/LO keep prior values; rst_n low at N+20 of a MULT -> all outputs 0 immediately, no done after release.

Source files
------------

// File: rtl/mult_div_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mult_div_unit: 32-step shift-add multiply / restoring divide, HI/LO    |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module mult_div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic             sign,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             flush,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {IDLE = 2'd0, PREP = 2'd1, CALC = 2'd2, FIX = 2'd3} state_t;

   state_t            state, state_next;
   logic              op_div, is_signed, neg_q, neg_r, dz;
   logic [WIDTH-1:0]  a_reg, b_reg, a_mag, b_mag, acc, q;
   logic [CNT_W-1:0]  cnt;

   logic [WIDTH-1:0]   abs_a, abs_b, acc_next, q_next, quo, rem, hi_res, lo_res;
   logic [WIDTH:0]     mul_sum, div_shift, div_diff;
   logic [2*WIDTH-1:0] product;

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start) state_next = PREP;
         PREP: state_next = (op_div && b_reg == '0) ? FIX : CALC;
         CALC: if (cnt == CNT_W'(WIDTH-1)) state_next = FIX;
         FIX:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (flush) state_next = IDLE;
   end

   always_comb begin
      abs_a     = (is_signed && a_reg[WIDTH-1]) ? -a_reg : a_reg;
      abs_b     = (is_signed && b_reg[WIDTH-1]) ? -b_reg : b_reg;
      // Multiply: {acc,q} is the product/multiplier pair, shifted right each step.
      mul_sum   = {1'b0, acc} + (q[0] ? {1'b0, a_mag} : {(WIDTH+1){1'b0}});
      // Divide: acc is the partial remainder, q shifts dividend out / quotient in.
      div_shift = {acc, q[WIDTH-1]};
      div_diff  = div_shift - {1'b0, b_mag};
      if (op_div) begin
         acc_next = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
         q_next   = {q[WIDTH-2:0], ~div_diff[WIDTH]};
      end else begin
         acc_next = mul_sum[WIDTH:1];
         q_next   = {mul_sum[0], q[WIDTH-1:1]};
      end
      product = neg_q ? -{acc, q} : {acc, q};
      quo     = neg_q ? -q : q;
      rem     = neg_r ? -acc : acc;
      if (dz) begin
         hi_res = a_reg;
         lo_res = '1;
      end else if (op_div) begin
         hi_res = rem;
         lo_res = quo;
      end else begin
         hi_res = product[2*WIDTH-1:WIDTH];
         lo_res = product[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi <= '0; lo <= '0; done <= 1'b0; div_zero <= 1'b0; cnt <= '0;
         op_div <= 1'b0; is_signed <= 1'b0; neg_q <= 1'b0; neg_r <= 1'b0; dz <= 1'b0;
         a_reg <= '0; b_reg <= '0; a_mag <= '0; b_mag <= '0; acc <= '0; q <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (mthi) hi <= wdata;
               if (mtlo) lo <= wdata;
               if (start && !flush) begin
                  op_div    <= (op == 2'd1);
                  is_signed <= sign;
                  a_reg     <= src_a;
                  b_reg     <= src_b;
               end
            end
            PREP: begin
               a_mag <= abs_a;
               b_mag <= abs_b;
               neg_q <= is_signed & (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
               neg_r <= is_signed & a_reg[WIDTH-1];
               dz    <= op_div && (b_reg == '0);
               acc   <= '0;
               q     <= op_div ? abs_a : abs_b;
               cnt   <= '0;
            end
            CALC: begin
               acc <= acc_next;
               q   <= q_next;
               cnt <= cnt + 1'b1;
            end
            FIX: begin
               if (!flush) begin
                  hi       <= hi_res;
                  lo       <= lo_res;
                  div_zero <= dz;
                  done     <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_mult_div_unit: directed self-checking bench for mult_div_unit       |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'd0;
   logic        sign = 1'b0;
   logic [31:0] src_a = '0, src_b = '0, wdata = '0;
   logic        flush = 1'b0, mthi = 1'b0, mtlo = 1'b0;
   logic        busy, done, div_zero;
   logic [31:0] hi, lo;

   int vectors = 0;
   int miscompares = 0;

   mult_div_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .sign(sign),
      .src_a(src_a), .src_b(src_b), .flush(flush), .mthi(mthi), .mtlo(mtlo),
      .wdata(wdata), .busy(busy), .done(done), .div_zero(div_zero),
      .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse start for one edge, then wait (bounded) for done; lat = -1 on timeout.
   task automatic issue(input logic [1:0] o, input logic s, input logic [31:0] a,
                        input logic [31:0] b, output int lat, output bit busy_ok);
      op = o; sign = s; src_a = a; src_b = b; start = 1'b1;
      tick();
      start = 1'b0;
      lat = 0;
      busy_ok = 1'b1;
      while (!done && lat < 60) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         tick();
         lat++;
      end
      if (!done) lat = -1;
   endtask

   task automatic test_reset();
      vectors++;
      if ({hi, lo, busy, done, div_zero} !== 67'd0) begin
         miscompares++;
         $display("FAIL reset: hi=%h lo=%h busy=%b done=%b dz=%b required all zero",
                  hi, lo, busy, done, div_zero);
      end
   endtask

   task automatic test_multu();
      int lat; bit bok;
      issue(2'd0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bok);
      vectors++;
      if (lat !== 34 || bok !== 1'b1) begin
         miscompares++;
         $display("FAIL multu_latency: lat=%0d busy_ok=%b required 34/1", lat, bok);
      end
      vectors++;
      if ({hi, lo, div_zero, busy} !== {32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL multu_result: hi=%h lo=%h dz=%b busy=%b required fffffffe 00000001 0 0",
                  hi, lo, div_zero, busy);
      end
      tick();
      vectors++;
      if (done !== 1'b0) begin
         miscompares++;
         $display("FAIL done_pulse: done=%b required 0", done);
      end
   endtask

   task automatic test_mult_signed();
      int lat; bit bok;
      issue(2'd0, 1'b1, 32'hFFFF_FFFD, 32'h0000_0007, lat, bok);
      vectors++;
      if (lat !== 34 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
         miscompares++;
         $display("FAIL mult_neg3x7: lat=%0d hi=%h lo=%h required 34 ffffffff ffffffeb", lat, hi, lo);
      end
      tick();
      issue(2'd2, 1'b1, 32'h8000_0000, 32'h8000_0000, lat, bok);
      vectors++;
      if (lat !== 34 || hi !== 32'h4000_0000 || lo !== 32'h0) begin
         miscompares++;
         $display("FAIL mult_minxmin: lat=%0d hi=%h lo=%h required 34 40000000 00000000", lat, hi, lo);
      end
      tick();
   endtask

   task automatic test_divide();
      int lat; bit bok;
      issue(2'd1, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, lat, bok);
      vectors++;
      if (lat !== 34 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
         miscompares++;
         $display("FAIL div_neg7by2: lat=%0d hi=%h lo=%h required 34 ffffffff fffffffd", lat, hi, lo);
      end
      tick();
      issue(2'd1, 1'b0, 32'd7, 32'd2, lat, bok);
      vectors++;
      if (lat !== 34 || hi !== 32'd1 || lo !== 32'd3) begin
         miscompares++;
         $display("FAIL divu_7by2: lat=%0d hi=%h lo=%h required 34 00000001 00000003", lat, hi, lo);
      end
      tick();
      issue(2'd1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, bok);
      vectors++;
      if (lat !== 34 || hi !== 32'h0 || lo !== 32'h8000_0000 || div_zero !== 1'b0) begin
         miscompares++;
         $display("FAIL div_overflow: lat=%0d hi=%h lo=%h dz=%b required 34 00000000 80000000 0",
                  lat, hi, lo, div_zero);
      end
      tick();
      issue(2'd1, 1'b1, 32'd100, 32'hFFFF_FFF9, lat, bok);
      vectors++;
      if (hi !== 32'd2 || lo !== 32'hFFFF_FFF2) begin
         miscompares++;
         $display("FAIL div_100byneg7: hi=%h lo=%h required 00000002 fffffff2", hi, lo);
      end
      tick();
   endtask

   task automatic test_div_zero();
      int lat; bit bok;
      issue(2'd1, 1'b0, 32'h0000_1234, 32'h0, lat, bok);
      vectors++;
      if (lat !== 2 || bok !== 1'b1 || hi !== 32'h0000_1234 || lo !== 32'hFFFF_FFFF || div_zero !== 1'b1) begin
         miscompares++;
         $display("FAIL div_by_zero: lat=%0d busy_ok=%b hi=%h lo=%h dz=%b required 2 1 00001234 ffffffff 1",
                  lat, bok, hi, lo, div_zero);
      end
      tick();
      vectors++;
      if (div_zero !== 1'b1) begin
         miscompares++;
         $display("FAIL dz_sticky: dz=%b required 1", div_zero);
      end
      issue(2'd0, 1'b0, 32'd2, 32'd3, lat, bok);
      vectors++;
      if (div_zero !== 1'b0 || hi !== 32'd0 || lo !== 32'd6) begin
         miscompares++;
         $display("FAIL dz_clear: dz=%b hi=%h lo=%h required 0 00000000 00000006", div_zero, hi, lo);
      end
      tick();
   endtask

   task automatic test_mt_regs();
      int lat; bit bok; int extra;
      wdata = 32'hAAAA_5555; mthi = 1'b1;
      tick();
      mthi = 1'b0;
      vectors++;
      if (hi !== 32'hAAAA_5555 || lo !== 32'd6) begin
         miscompares++;
         $display("FAIL mthi_idle: hi=%h lo=%h required aaaa5555 00000006", hi, lo);
      end
      op = 2'd0; sign = 1'b0; src_a = 32'd5; src_b = 32'd7; start = 1'b1;
      tick();
      // Keep start high with new operands and write LO while busy: both ignored.
      src_a = 32'd9; src_b = 32'd9; wdata = 32'h1; mtlo = 1'b1;
      repeat (5) tick();
      start = 1'b0; mtlo = 1'b0;
      vectors++;
      if (lo !== 32'd6 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL mtlo_busy: lo=%h busy=%b required 00000006 1", lo, busy);
      end
      lat = 0;
      while (!done && lat < 60) begin tick(); lat++; end
      vectors++;
      if (done !== 1'b1 || hi !== 32'd0 || lo !== 32'd35) begin
         miscompares++;
         $display("FAIL mult_after_mt: done=%b hi=%h lo=%h required 1 00000000 00000023", done, hi, lo);
      end
      extra = 0;
      repeat (40) begin tick(); if (done) extra++; end
      vectors++;
      if (extra !== 0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL single_done: extra_done=%0d busy=%b required 0 0", extra, busy);
      end
      wdata = 32'h1357_9BDF; mthi = 1'b1; mtlo = 1'b1;
      tick();
      mthi = 1'b0; mtlo = 1'b0;
      vectors++;
      if (hi !== 32'h1357_9BDF || lo !== 32'h1357_9BDF) begin
         miscompares++;
         $display("FAIL mthi_mtlo: hi=%h lo=%h required 13579bdf 13579bdf", hi, lo);
      end
   endtask

   task automatic test_back_to_back();
      int lat; bit bok;
      issue(2'd0, 1'b0, 32'd3, 32'd4, lat, bok);
      vectors++;
      if (lo !== 32'd12 || hi !== 32'd0) begin
         miscompares++;
         $display("FAIL b2b_first: hi=%h lo=%h required 00000000 0000000c", hi, lo);
      end
      issue(2'd1, 1'b0, 32'd100, 32'd7, lat, bok);
      vectors++;
      if (lat !== 34 || bok !== 1'b1 || hi !== 32'd2 || lo !== 32'd14) begin
         miscompares++;
         $display("FAIL b2b_second: lat=%0d busy_ok=%b hi=%h lo=%h required 34 1 00000002 0000000e",
                  lat, bok, hi, lo);
      end
      tick();
   endtask

   task automatic test_flush();
      int seen;
      op = 2'd1; sign = 1'b1; src_a = 32'hFFFF_FFF9; src_b = 32'd2; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (9) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_busy: busy=%b required 0", busy);
      end
      seen = 0;
      repeat (40) begin if (done) seen++; tick(); end
      vectors++;
      if (seen !== 0 || hi !== 32'd2 || lo !== 32'd14 || div_zero !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_hold: dones=%0d hi=%h lo=%h dz=%b required 0 00000002 0000000e 0",
                  seen, hi, lo, div_zero);
      end
      start = 1'b1; flush = 1'b1;
      tick();
      start = 1'b0; flush = 1'b0;
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_idle_start: busy=%b required 0", busy);
      end
   endtask

   task automatic test_reset_mid();
      int seen;
      op = 2'd0; sign = 1'b0; src_a = 32'd11; src_b = 32'd13; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (19) tick();
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if ({hi, lo, busy, done, div_zero} !== 67'd0) begin
         miscompares++;
         $display("FAIL async_reset: hi=%h lo=%h busy=%b done=%b dz=%b required all zero",
                  hi, lo, busy, done, div_zero);
      end
      tick();
      rst_n = 1'b1;
      seen = 0;
      repeat (40) begin tick(); if (done || busy) seen++; end
      vectors++;
      if (seen !== 0 || lo !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_discard: activity=%0d lo=%h required 0 00000000", seen, lo);
      end
   endtask

   initial begin
      repeat (3) tick();
      test_reset();
      rst_n = 1'b1;
      tick();
      test_multu();
      test_mult_signed();
      test_divide();
      test_div_zero();
      test_mt_regs();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
